// File: rtl/my_gate_pipe.sv
// my_gate_pipe: LANES independent WIDTH-input reduction gates with a
// run-time selected op and a registered valid/ready output stage.
// Optional statistics counters are enabled by defining GATE_STATS_EN.
// Without that macro, acc_cnt and one_cnt are tied to zero.
module my_gate_pipe #(
  parameter int WIDTH = 2,
  parameter int LANES = 1,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*LANES-1:0] in_data,
  input  logic [2:0]             op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES-1:0]       out_x,
  output logic                   op_err,
  output logic [CNT_W-1:0]       acc_cnt,
  output logic [CNT_W-1:0]       one_cnt
);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_BUF  = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  logic             accept;
  logic [LANES-1:0] gate_res;
  logic [WIDTH-1:0] lane_d;

  // The stage can take new data whenever it is empty or is being drained this cycle.
  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // Per-lane reduction selected by op; the reserved op forces every lane to 0.
  always_comb begin
    gate_res = '0;
    lane_d   = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_d = in_data[k*WIDTH +: WIDTH];
      case (op)
        OP_AND:  gate_res[k] = &lane_d;
        OP_OR:   gate_res[k] = |lane_d;
        OP_XOR:  gate_res[k] = ^lane_d;
        OP_NAND: gate_res[k] = ~&lane_d;
        OP_NOR:  gate_res[k] = ~|lane_d;
        OP_XNOR: gate_res[k] = ~^lane_d;
        OP_BUF:  gate_res[k] = lane_d[0];
        default: gate_res[k] = 1'b0;
      endcase
    end
  end

  // Output register: load on accept, drop valid on drain, freeze while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_x     <= '0;
      op_err    <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_x     <= gate_res;
      if (op == OP_RSVD) begin
        op_err <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef GATE_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Saturating counts of accepted transactions and of those whose lane-0 result is 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt <= '0;
      one_cnt <= '0;
    end else if (accept) begin
      if (acc_cnt != CNT_MAX) begin
        acc_cnt <= acc_cnt + CNT_ONE;
      end
      if (gate_res[0] && (one_cnt != CNT_MAX)) begin
        one_cnt <= one_cnt + CNT_ONE;
      end
    end
  end
`else
  assign acc_cnt = '0;
  assign one_cnt = '0;
`endif

endmodule

// File: tb/tb_my_gate_pipe.sv
// Self-checking bench for my_gate_pipe (WIDTH=4, LANES=2, CNT_W=4) against
// a transaction-level reference model kept in the bench.
module tb_my_gate_pipe;

  localparam int W = 4;
  localparam int L = 2;
  localparam int C = 4;
`ifdef GATE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam logic [C-1:0] SAT = {C{1'b1}};

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W*L-1:0] in_data = '0;
  logic [2:0]     op = 3'd0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [L-1:0]   out_x;
  logic           op_err;
  logic [C-1:0]   acc_cnt;
  logic [C-1:0]   one_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic         m_valid = 1'b0;
  logic [L-1:0] m_x = '0;
  logic         m_err = 1'b0;
  logic [C-1:0] m_acc = '0;
  logic [C-1:0] m_one = '0;

  my_gate_pipe #(.WIDTH(W), .LANES(L), .CNT_W(C)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .op_err(op_err), .acc_cnt(acc_cnt), .one_cnt(one_cnt)
  );

  always #5 clk = ~clk;

  // gate result computed from the number of ones in the lane
  function automatic logic ref_gate(input logic [2:0] o, input logic [W-1:0] d);
    int ones;
    ones = $countones(d);
    case (o)
      3'd0: return ones == W;
      3'd1: return ones > 0;
      3'd2: return (ones % 2) == 1;
      3'd3: return ones != W;
      3'd4: return ones == 0;
      3'd5: return (ones % 2) == 0;
      3'd6: return d[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [L-1:0] ref_x(input logic [2:0] o, input logic [W*L-1:0] d);
    logic [L-1:0] r;
    r = '0;
    for (int k = 0; k < L; k++) r[k] = ref_gate(o, d[k*W +: W]);
    return r;
  endfunction

  // drive one cycle from a negedge, advance the model at the posedge, return at the next negedge
  task automatic apply(input logic v, input logic [W*L-1:0] d, input logic [2:0] o, input logic r);
    logic acc;
    in_valid = v; in_data = d; op = o; out_ready = r;
    @(posedge clk);
    acc = v & (!m_valid | r);
    if (acc) begin
      m_x = ref_x(o, d);
      m_valid = 1'b1;
      if (o == 3'd7) m_err = 1'b1;
      if (STATS) begin
        if (m_acc != SAT) m_acc = m_acc + 1'b1;
        if (m_x[0] && m_one != SAT) m_one = m_one + 1'b1;
      end
    end else if (r) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  // raise reset off the clock edge, reset the model, release at the next negedge
  task automatic pulse_reset_start();
    #2 rst = 1'b1;
    in_valid = 1'b0;
    #1;
    m_valid = 1'b0; m_x = '0; m_err = 1'b0; m_acc = '0; m_one = '0;
  endtask

  task automatic pulse_reset_end();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (out_valid !== 1'b0 || out_x !== '0 || op_err !== 1'b0 || acc_cnt !== '0 || one_cnt !== '0) begin
      n_err++;
      $display("FAIL reset_state: valid=%b x=%b err=%b acc=%h one=%h required 0/0/0/0/0",
               out_valid, out_x, op_err, acc_cnt, one_cnt);
    end
    rst = 1'b0;
    apply(1'b0, '0, 3'd0, 1'b0);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: in_ready=%b valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_and_sweep();
    logic [W-1:0] pat [4];
    logic [W*L-1:0] d;
    pat[0] = 4'h0; pat[1] = 4'h1; pat[2] = 4'hE; pat[3] = 4'hF;
    for (int i = 0; i < 4; i++) begin
      d = {pat[3-i], pat[i]};
      apply(1'b1, d, 3'd0, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b1 || out_x !== m_x || out_x[0] !== (i == 3)) begin
        n_err++;
        $display("FAIL and_sweep[%0d]: valid=%b x=%b required 1/%b", i, out_valid, out_x, m_x);
      end
    end
  endtask

  task automatic test_xor_xnor();
    apply(1'b1, 8'hF3, 3'd2, 1'b1);
    n_cmp++;
    if (out_x !== 2'b00 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL xor_f3: x=%b valid=%b required 00/1", out_x, out_valid);
    end
    apply(1'b1, 8'hF3, 3'd5, 1'b1);
    n_cmp++;
    if (out_x !== 2'b11 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL xnor_f3: x=%b valid=%b required 11/1", out_x, out_valid);
    end
    apply(1'b1, 8'h2C, 3'd6, 1'b1);
    n_cmp++;
    if (out_x !== 2'b00) begin
      n_err++;
      $display("FAIL buf_2c: x=%b required 00", out_x);
    end
  endtask

  task automatic test_stall();
    apply(1'b1, 8'h01, 3'd1, 1'b1);
    n_cmp++;
    if (out_x !== 2'b01 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL stall_load: x=%b valid=%b required 01/1", out_x, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 8'($urandom), 3'($urandom_range(0, 7)), 1'b0);
      n_cmp++;
      if (out_x !== 2'b01 || out_valid !== 1'b1 || in_ready !== 1'b0 || op_err !== m_err) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: x=%b valid=%b in_ready=%b err=%b required 01/1/0/%b",
                 i, out_x, out_valid, in_ready, op_err, m_err);
      end
    end
    apply(1'b0, 8'hFF, 3'd0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b0 || out_x !== 2'b01 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL stall_drain: valid=%b x=%b in_ready=%b required 0/01/1", out_valid, out_x, in_ready);
    end
    apply(1'b1, 8'hF0, 3'd0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_x !== 2'b10) begin
      n_err++;
      $display("FAIL stall_next: valid=%b x=%b required 1/10", out_valid, out_x);
    end
  endtask

  task automatic test_back_to_back();
    logic [C-1:0] acc0;
    acc0 = acc_cnt;
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 8'($urandom), 3'(i % 6), 1'b1);
      n_cmp++;
      if (out_valid !== 1'b1 || out_x !== m_x || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b[%0d]: valid=%b x=%b in_ready=%b required 1/%b/1", i, out_valid, out_x, in_ready, m_x);
      end
    end
    n_cmp++;
    if (acc_cnt !== m_acc) begin
      n_err++;
      $display("FAIL b2b_count: acc=%h (was %h) required %h", acc_cnt, acc0, m_acc);
    end
  endtask

  task automatic test_random();
    logic [2:0] o;
    for (int i = 0; i < 300; i++) begin
      o = ($urandom_range(0, 15) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
      apply(1'($urandom_range(0, 3) != 0), 8'($urandom), o, 1'($urandom_range(0, 2) != 0));
      n_cmp++;
      if (out_valid !== m_valid || out_x !== m_x || op_err !== m_err ||
          acc_cnt !== m_acc || one_cnt !== m_one || in_ready !== (!m_valid | out_ready)) begin
        n_err++;
        $display("FAIL random[%0d]: valid=%b x=%b err=%b acc=%h one=%h rdy=%b required %b/%b/%b/%h/%h/%b",
                 i, out_valid, out_x, op_err, acc_cnt, one_cnt, in_ready,
                 m_valid, m_x, m_err, m_acc, m_one, (!m_valid | out_ready));
      end
    end
  endtask

  task automatic test_reserved();
    pulse_reset_start();
    pulse_reset_end();
    apply(1'b1, 8'hFF, 3'd7, 1'b1);
    n_cmp++;
    if (out_x !== 2'b00 || op_err !== 1'b1 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rsvd_accept: x=%b err=%b valid=%b required 00/1/1", out_x, op_err, out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 8'($urandom), 3'(i), 1'b1);
      n_cmp++;
      if (op_err !== 1'b1 || out_x !== m_x) begin
        n_err++;
        $display("FAIL rsvd_sticky[%0d]: err=%b x=%b required 1/%b", i, op_err, out_x, m_x);
      end
    end
    pulse_reset_start();
    n_cmp++;
    if (op_err !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rsvd_clear: err=%b valid=%b required 0/0", op_err, out_valid);
    end
    pulse_reset_end();
  endtask

  task automatic test_stats();
    logic [C-1:0] lit;
    lit = STATS ? SAT : '0;
    for (int i = 0; i < 20; i++) apply(1'b1, 8'h01, 3'd1, 1'b1);
    n_cmp++;
    if (acc_cnt !== lit || one_cnt !== lit || acc_cnt !== m_acc || one_cnt !== m_one) begin
      n_err++;
      $display("FAIL stats_sat: acc=%h one=%h required %h/%h", acc_cnt, one_cnt, lit, lit);
    end
    pulse_reset_start();
    n_cmp++;
    if (acc_cnt !== '0 || one_cnt !== '0) begin
      n_err++;
      $display("FAIL stats_reset: acc=%h one=%h required 0/0", acc_cnt, one_cnt);
    end
    pulse_reset_end();
    apply(1'b1, 8'h01, 3'd1, 1'b0);
    apply(1'b1, 8'h10, 3'd1, 1'b0);
    pulse_reset_start();
    n_cmp++;
    if (out_valid !== 1'b0 || out_x !== '0 || acc_cnt !== '0 || one_cnt !== '0) begin
      n_err++;
      $display("FAIL stall_reset: valid=%b x=%b acc=%h one=%h required 0/00/0/0", out_valid, out_x, acc_cnt, one_cnt);
    end
    pulse_reset_end();
    apply(1'b0, '0, 3'd0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b0 || acc_cnt !== '0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL stall_reset_after: valid=%b acc=%h rdy=%b required 0/0/1", out_valid, acc_cnt, in_ready);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_and_sweep();
    test_xor_xnor();
    test_stall();
    test_back_to_back();
    test_random();
    test_reserved();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
